// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the 007121 graphics path: pixel field layout,
// line-buffer geometry and the blank pixel value.
package jtcontra_gfx_pkg;

  // Pixel word layout: {scrwin, pal[3:0], colour[3:0]}
  localparam int unsigned SCRWIN_BIT = 8;
  localparam int unsigned PAL_MSB    = 7;
  localparam int unsigned PAL_LSB    = 4;
  localparam int unsigned COL_MSB    = 3;

  // {half, column} address into the double-buffered line store
  localparam int unsigned LINE_AW    = 10;

  localparam logic [8:0]  BLANK_PXL  = 9'd0;

  typedef enum logic {
    HALF_0 = 1'b0,
    HALF_1 = 1'b1
  } half_e;

  // Colour index 0 is the transparent pen
  function automatic logic col_opaque(input logic [COL_MSB:0] col);
    return col != '0;
  endfunction

endpackage

// File: rtl/jtcontra_linebuf_ram.sv
// 1024 x DW true dual-port line RAM: port A write-only from the renderer,
// port B read/clear for scanout. Write-first, port A wins on address clash.
module jtcontra_linebuf_ram
  import jtcontra_gfx_pkg::*;
#(
  parameter int unsigned DW = 9,
  parameter int unsigned AW = LINE_AW
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          clash;

  assign clash = we_a && (addr_a == addr_b);

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= din_a;
    end
    if (we_b && !clash) begin
      mem[addr_b] <= din_b;
    end
    if (clash) begin
      q_b <= din_a;
    end else if (we_b) begin
      q_b <= din_b;
    end else begin
      q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/jtcontra_gfx_linebuf.sv
// Double-buffered scan-line store with pixel scanout and optional
// clear-after-read (enabled by defining JTCONTRA_LINEBUF_CLR_EN).
module jtcontra_gfx_linebuf
  import jtcontra_gfx_pkg::*;
#(
  parameter int unsigned DW      = 9,
  parameter logic [8:0]  HOFFSET = 9'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pxl_cen,
  input  logic               HS,
  input  logic               LHBL,
  input  logic [8:0]         hdump,
  input  logic               line,
  input  logic               we,
  input  logic [LINE_AW-1:0] wr_addr,
  input  logic [DW-1:0]      din,
  input  logic               txt_line,
  output logic [DW-1:0]      pxl,
  output logic               opaque,
  output logic               pxl_txt
);

`ifdef JTCONTRA_LINEBUF_CLR_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif

  half_e              rd_half;
  logic [8:0]         rd_col;
  logic [LINE_AW-1:0] rd_next;
  logic [LINE_AW-1:0] rd_addr;
  logic [LINE_AW-1:0] ram_addr_b;
  logic               cap_pend;
  logic               clr_pend;
  logic               lhbl_rd;
  logic [DW-1:0]      rd_data;
  logic [DW-1:0]      q_b;
  logic               hs_d;

  // The RAM sees the new address in the pxl_cen cycle so data is ready one
  // clk later; the clear reuses the captured rd_addr, keeping its half.
  always_comb begin
    rd_col     = hdump + HOFFSET;
    rd_next    = {rd_half, rd_col};
    ram_addr_b = clr_pend ? rd_addr : rd_next;
  end

  jtcontra_linebuf_ram #(
    .DW (DW),
    .AW (LINE_AW)
  ) u_ram (
    .clk    (clk),
    .we_a   (we),
    .addr_a (wr_addr),
    .din_a  (din),
    .we_b   (clr_pend),
    .addr_b (ram_addr_b),
    .din_b  ('0),
    .q_b    (q_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_half  <= HALF_1;
      rd_addr  <= '0;
      cap_pend <= 1'b0;
      clr_pend <= 1'b0;
      lhbl_rd  <= 1'b0;
      rd_data  <= '0;
      pxl      <= '0;
      opaque   <= 1'b0;
      hs_d     <= 1'b0;
      pxl_txt  <= 1'b0;
    end else begin
      rd_half  <= line ? HALF_0 : HALF_1;
      cap_pend <= pxl_cen;
      clr_pend <= pxl_cen & CLR_EN;
      if (pxl_cen) begin
        rd_addr <= rd_next;
        lhbl_rd <= LHBL;
        pxl     <= lhbl_rd ? rd_data : DW'(BLANK_PXL);
        opaque  <= lhbl_rd && col_opaque(rd_data[COL_MSB:0]);
      end
      if (cap_pend) begin
        rd_data <= q_b;
      end
      hs_d <= HS;
      if (HS && !hs_d) begin
        pxl_txt <= txt_line;
      end
    end
  end

endmodule

// File: tb/tb_jtcontra_gfx_linebuf.sv
// Directed self-checking bench for jtcontra_gfx_linebuf; expectations follow
// JTCONTRA_LINEBUF_CLR_EN when it is defined for the build.
module tb_jtcontra_gfx_linebuf;

  logic       clk = 1'b0;
  logic       rst, pxl_cen, HS, LHBL, line, we, txt_line;
  logic [8:0] hdump;
  logic [9:0] wr_addr;
  logic [8:0] din;
  logic [8:0] pxl;
  logic       opaque, pxl_txt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef JTCONTRA_LINEBUF_CLR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  jtcontra_gfx_linebuf #(.DW(9), .HOFFSET(9'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .HS       (HS),
    .LHBL     (LHBL),
    .hdump    (hdump),
    .line     (line),
    .we       (we),
    .wr_addr  (wr_addr),
    .din      (din),
    .txt_line (txt_line),
    .pxl      (pxl),
    .opaque   (opaque),
    .pxl_txt  (pxl_txt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [8:0] h);
    hdump   = h;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [9:0] a, input logic [8:0] d);
    we      = 1'b1;
    wr_addr = a;
    din     = d;
    tick();
    we      = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; HS = 1'b0; LHBL = 1'b1; line = 1'b0;
    we = 1'b0; txt_line = 1'b0; hdump = '0; wr_addr = '0; din = '0;
    tick(); tick();
    chk("rst_pxl", pxl, 9'h000);
    chk("rst_opaque", {8'd0, opaque}, 9'd0);
    chk("rst_txt", {8'd0, pxl_txt}, 9'd0);
    rst = 1'b0;

    // Write then read, opacity, clear-after-read, blanking
    wr({1'b0, 9'd20}, 9'h1A5);
    wr({1'b0, 9'd21}, 9'h010);
    wr({1'b0, 9'd22}, 9'h0F3);
    wr({1'b0, 9'd23}, 9'h1C7);
    line = 1'b1;
    tick();
    pulse(9'd20);
    pulse(9'd21);
    chk("rd20_pxl", pxl, 9'h1A5);
    chk("rd20_opaque", {8'd0, opaque}, 9'd1);
    pulse(9'd20);
    chk("rd21_pxl", pxl, 9'h010);
    chk("rd21_opaque", {8'd0, opaque}, 9'd0);
    pulse(9'd22);
    chk("reread20_pxl", pxl, CLR ? 9'h000 : 9'h1A5);
    chk("reread20_opaque", {8'd0, opaque}, CLR ? 9'd0 : 9'd1);
    LHBL = 1'b0;
    pulse(9'd22);
    chk("rd22_pxl", pxl, 9'h0F3);
    LHBL = 1'b1;
    pulse(9'd23);
    chk("blank_pxl", pxl, 9'h000);
    chk("blank_opaque", {8'd0, opaque}, 9'd0);
    pulse(9'd23);
    chk("rd23_pxl", pxl, 9'h1C7);

    // Swap in flight with a colliding renderer write
    line = 1'b0;
    tick();
    wr({1'b1, 9'd5}, 9'h0AA);
    wr({1'b0, 9'd5}, 9'h1E1);
    hdump   = 9'd5;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    line    = 1'b1;
    we      = 1'b1;
    wr_addr = {1'b1, 9'd5};
    din     = 9'h055;
    tick();
    we      = 1'b0;
    pulse(9'd23);
    chk("swap_rd_pxl", pxl, 9'h0AA);
    line = 1'b0;
    tick();
    pulse(9'd5);
    pulse(9'd5);
    chk("collide_survive", pxl, 9'h055);
    line = 1'b1;
    tick();
    pulse(9'd5);
    pulse(9'd5);
    chk("other_half_kept", pxl, 9'h1E1);

    // Text flag
    txt_line = 1'b1;
    HS = 1'b1;
    chk("txt_before_edge", {8'd0, pxl_txt}, 9'd0);
    tick();
    chk("txt_set", {8'd0, pxl_txt}, 9'd1);
    txt_line = 1'b0;
    tick(); tick(); tick();
    HS = 1'b0;
    tick(); tick(); tick();
    chk("txt_hold", {8'd0, pxl_txt}, 9'd1);
    HS = 1'b1;
    tick();
    chk("txt_clear", {8'd0, pxl_txt}, 9'd0);
    HS = 1'b0;
    tick();

    // Reset mid-line
    txt_line = 1'b1;
    HS = 1'b1;
    tick();
    chk("txt_pre_rst", {8'd0, pxl_txt}, 9'd1);
    line = 1'b0;
    tick();
    wr({1'b1, 9'd30}, 9'h1FF);
    wr({1'b1, 9'd32}, 9'h000);
    wr({1'b1, 9'd33}, 9'h1B2);
    pulse(9'd30);
    pulse(9'd32);
    chk("pre_rst_pxl", pxl, 9'h1FF);
    txt_line = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_pxl", pxl, 9'h000);
    chk("midrst_opaque", {8'd0, opaque}, 9'd0);
    chk("midrst_txt", {8'd0, pxl_txt}, 9'd0);
    rst = 1'b0;
    pulse(9'd33);
    chk("post_rst_first", pxl, 9'h000);
    pulse(9'd30);
    chk("post_rst_pxl", pxl, 9'h1B2);
    chk("post_rst_opaque", {8'd0, opaque}, 9'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtcontra_gfx_linebuf.md
# jtcontra_gfx_linebuf

Double-buffered scan-line store and pixel scanout for the 007121 graphics path. It sits directly downstream of the tilemap renderer. It accepts the renderer's 9-bit pixel writes into the half selected by `line`, and scans the opposite half out in step with `hdump` at the pixel clock enable. Each location is optionally erased after it is read, so every line starts blank. The output feeds the colour mixer/palette stage.

## Interface

**Parameters**
- `DW`, default 9: pixel word width, `{scrwin, pal[3:0], colour[3:0]}`.
- `HOFFSET`, default 9'd0: constant added to `hdump` to form the read address.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `pxl_cen`  in  1: pixel clock enable. Guaranteed at most one pulse every 2 `clk` cycles.
- `HS`  in  1: horizontal sync.
- `LHBL`  in  1: horizontal blank, active low.
- `hdump`  in  9: current display column.
- `line`  in  1: half currently being written by the renderer.
- `we`  in  1: renderer write strobe.
- `wr_addr`  in  10: `{half, column}` write address.
- `din`  in  DW: renderer pixel.
- `txt_line`  in  1: the line the renderer just finished was a text row.
- `pxl`  out  DW: displayed pixel.
- `opaque`  out  1: `pxl[3:0] != 0`.
- `pxl_txt`  out  1: the displayed line is a text row.

## Operation

**Write port (port A)**
- When `we` is high, store `din` at `wr_addr` in every `clk` cycle.
- No other gating is applied.

**Read half**
- `rd_half` is registered every `clk` as `~line`.
- The half bit is captured together with the address at issue. A read or clear in flight therefore always completes on the half it started on, even across a `line` toggle.

**Scanout (port B)** is a three-step sequence:
- READ: on `pxl_cen`, `rd_addr <= {rd_half, hdump + HOFFSET}`. The 9-bit sum wraps modulo 512.
- CAPTURE: on the next `clk`, RAM data is valid and is held in `rd_data`. With the macro enabled, a zero write is issued to `rd_addr` in this same cycle.
- OUTPUT: on the next `pxl_cen`, `pxl <= LHBL_d ? rd_data : 0`. Here `LHBL_d` is `LHBL` aligned to the read.

**Blanking and opacity**
- `opaque` is registered together with `pxl`. It is 0 whenever `pxl` is forced to 0.
- During vertical blank `line` does not toggle, so the same half is re-read. With the macro enabled it reads as zeros.

**Text flag**
- On each `HS` rising edge, `pxl_txt <= txt_line`.
- `pxl_txt` holds for the whole displayed line.

**Collision rule**
- If port A and a port-B clear hit the same address in the same cycle, port A wins.
- This can only occur one cycle after a `line` toggle. It must not corrupt the write.

**Reset (`rst`)**
- `pxl = 0`, `opaque = 0`, `pxl_txt = 0`, `rd_addr = 0`, `rd_half = 1`, and any pending clear is dropped.
- RAM contents are not initialised.
- A reset asserted mid-line takes effect at the next `clk`. Scanout resumes on the first `pxl_cen` after release.

## Timing

- Write-to-read visibility: one `clk`.
- Read latency: `pxl` shows column `h` two `pxl_cen` pulses after `hdump == h`, with `HOFFSET = 0`.
- Clear timing: the clear completes one `clk` after the read, before the next `pxl_cen`. The minimum 2-cycle `pxl_cen` spacing guarantees this.
- Line swap: a `line` toggle affects reads issued from the next `pxl_cen` onward.
- `pxl_txt` updates one `clk` after the `HS` rising edge.

## Configuration

`JTCONTRA_LINEBUF_CLR_EN`
- **Defined:** the port-B zero write is issued after every read. Locations not rendered this line read as 0 (transparent).
- **Undefined:** no clear is issued and port B is read-only. Stale data persists until overwritten, so the renderer must fill the full line.

## Structure

**Shared package `jtcontra_gfx_pkg`**
- Pixel field offsets: `SCRWIN_BIT = 8`, `PAL_MSB = 7`, `PAL_LSB = 4`, `COL_MSB = 3`.
- `LINE_AW = 10`.
- Constant `BLANK_PXL = 9'd0`.

**Sub-module `jtcontra_linebuf_ram`**
- True dual-port RAM, 1024 × `DW`.
- Registered read on port B.
- Write-first on both ports, with port-A priority on address clash.

## Test plan

- **Write then read:** write `din = 9'h1A5` at `{0, 9'd20}` with `line = 0`, then toggle `line` to 1 → `pxl = 9'h1A5` and `opaque = 1` two `pxl_cen` pulses after `hdump = 20`.
- **Clear-after-read (macro defined):** after the read above, the next line reads `{0, 20}` without rewriting → `pxl = 0`, `opaque = 0`. With the macro undefined → `9'h1A5` again.
- **Blanking:** hold `LHBL = 0` while reading a location holding `9'h0F3` → `pxl = 0`, `opaque = 0`.
- **Swap in flight:** toggle `line` one `clk` after a `pxl_cen` read of `{1, 9'd5}` → the clear lands on half 1. A renderer write of `9'h055` to `{1, 9'd5}` in that same cycle survives.
- **Text flag:** `txt_line = 1` at `HS` rising edge, then 0 mid-line → `pxl_txt = 1` for the whole line and 0 after the next `HS` edge.
- **Reset mid-line:** assert `rst` while `pxl = 9'h1FF` → `pxl = 0`, `pxl_txt = 0` on the next `clk`, and the first valid pixel appears two `pxl_cen` pulses after release.
